// File: rtl/button_conditioner_pkg.sv
// Shared Pong definitions: button channel FSM states, button indices and debounce defaults.
package pong_pkg;

    localparam int unsigned N_BTN_DEFAULT           = 32'd5;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd1_000_000;

    localparam int unsigned BTN_C = 32'd0;
    localparam int unsigned BTN_U = 32'd1;
    localparam int unsigned BTN_D = 32'd2;
    localparam int unsigned BTN_L = 32'd3;
    localparam int unsigned BTN_R = 32'd4;

    typedef enum logic [1:0] {
        CH_IDLE         = 2'd0,
        CH_PRESS_WAIT   = 2'd1,
        CH_HELD         = 2'd2,
        CH_RELEASE_WAIT = 2'd3
    } chan_state_e;

    // Debounce counter width; a one-bit floor keeps degenerate parameters legal.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        return (w < 32'd1) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the Pong game logic.
interface button_conditioner_if #(
    parameter int unsigned N_BTN = 32'd5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/button_conditioner_channel.sv
// One button: 2-FF synchroniser, debounce FSM with stability counter, registered level and pulses.
module debounce_channel
    import pong_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_ZERO = '0;
    localparam logic [CW-1:0]  CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

    logic        r_sync1;
    logic        r_sync2;
    chan_state_e r_state;
    logic [CW-1:0] r_cnt;
    logic        r_level;
    logic        r_press;
    logic        r_release;

    chan_state_e w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic        w_level_nxt;
    logic        w_press_nxt;
    logic        w_release_nxt;

    // Two-stage synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state logic: any opposite sample during a WAIT state abandons the candidate level.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            CH_IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = CH_PRESS_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            CH_PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_state_nxt = CH_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = CH_HELD;
                    w_cnt_nxt   = CNT_ZERO;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            CH_HELD: begin
                if (!r_sync2) begin
                    w_state_nxt = CH_RELEASE_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            CH_RELEASE_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt = CH_HELD;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = CH_IDLE;
                    w_cnt_nxt     = CNT_ZERO;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt     = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = CH_IDLE;
                w_cnt_nxt   = CNT_ZERO;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    // FSM, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= CH_IDLE;
            r_cnt     <= CNT_ZERO;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// Conditions all push-buttons: one independent debounce channel per button bit.
module button_conditioner
    import pong_pkg::*;
#(
    parameter int unsigned N_BTN           = N_BTN_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    button_conditioner_if.slave btn_if
);

    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_release;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_raw     (btn_if.btn_raw[g]),
            .o_level   (w_level[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g])
        );
    end

    assign btn_if.btn_level   = w_level;
    assign btn_if.btn_press   = w_press;
    assign btn_if.btn_release = w_release;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: hand sequences, a segment table and random stimulus against a sliding-window model.
module tb_button_conditioner;

    localparam int N = 5;
    localparam int D = 4;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    button_conditioner_if #(.N_BTN(N)) bif ();

    button_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_if  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: two-stage pin delay, then a level flips once the last D delayed samples all oppose it.
    logic [N-1:0] m_p0, m_p1;
    logic [N-1:0] m_level, m_press, m_release;
    logic [N-1:0] win[$];

    task automatic model_edge();
        logic [N-1:0] s;
        bit ok;
        if (!reset_n) begin
            m_p0 = '0; m_p1 = '0;
            win.delete();
            m_level = '0; m_press = '0; m_release = '0;
        end else begin
            s = m_p1;
            win.push_back(s);
            if (win.size() > D) void'(win.pop_front());
            m_press = '0; m_release = '0;
            for (int ch = 0; ch < N; ch++) begin
                ok = (win.size() == D);
                foreach (win[k]) if (win[k][ch] == m_level[ch]) ok = 1'b0;
                if (ok) begin
                    m_level[ch] = ~m_level[ch];
                    if (m_level[ch]) m_press[ch] = 1'b1;
                    else             m_release[ch] = 1'b1;
                end
            end
            m_p1 = m_p0;
            m_p0 = bif.btn_raw;
        end
    endtask

    task automatic chk(input string name, input logic [3*N-1:0] act, input logic [3*N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got lvl/prs/rel=%b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model at the edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model", {bif.btn_level, bif.btn_press, bif.btn_release}, {m_level, m_press, m_release});
    endtask

    // Expect no pulses for n-1 cycles, then exact outputs on the n-th.
    task automatic expect_after(input int n, input logic [N-1:0] lvl, input logic [N-1:0] prs,
                                input logic [N-1:0] rel, input string name);
        for (int i = 0; i < n - 1; i++) begin
            step();
            chk({name, "_early"}, {bif.btn_press, bif.btn_release, 5'b0}, 15'b0);
        end
        step();
        chk(name, {bif.btn_level, bif.btn_press, bif.btn_release}, {lvl, prs, rel});
    endtask

    typedef struct {
        logic [N-1:0] raw;
        int           hold;
        logic [N-1:0] level;
        int           n_press;
        int           n_rel;
    } seg_t;

    seg_t segs[$];

    initial begin
        int np, nr;
        tests = 0; fails = 0;
        m_p0 = '0; m_p1 = '0; m_level = '0; m_press = '0; m_release = '0;

        // Button held through reset: outputs quiet, then a normal press.
        reset_n = 1'b0;
        bif.btn_raw = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_quiet", {bif.btn_level, bif.btn_press, bif.btn_release}, 15'b0);
        end
        reset_n = 1'b1;
        expect_after(6, 5'b11111, 5'b11111, 5'b00000, "post_reset_press");
        step();
        chk("press_one_cycle", {bif.btn_press, 10'b0}, 15'b0);
        bif.btn_raw = 5'b00000;
        expect_after(6, 5'b00000, 5'b00000, 5'b11111, "release_all");

        // Clean press and release on U.
        step(); step();
        bif.btn_raw = 5'b00010;
        expect_after(6, 5'b00010, 5'b00010, 5'b00000, "clean_press");
        for (int i = 0; i < 4; i++) step();
        bif.btn_raw = 5'b00000;
        expect_after(6, 5'b00000, 5'b00000, 5'b00010, "clean_release");
        step(); step();

        // Segment table: bounce, glitch lengths, simultaneous buttons.
        segs.push_back('{5'b01000, 1, 5'b00000, 0, 0});
        segs.push_back('{5'b00000, 1, 5'b00000, 0, 0});
        segs.push_back('{5'b01000, 1, 5'b00000, 0, 0});
        segs.push_back('{5'b00000, 1, 5'b00000, 0, 0});
        segs.push_back('{5'b01000, 5, 5'b00000, 0, 0});
        segs.push_back('{5'b01000, 1, 5'b01000, 1, 0});
        segs.push_back('{5'b00000, 6, 5'b00000, 0, 1});
        segs.push_back('{5'b00100, 3, 5'b00000, 0, 0});
        segs.push_back('{5'b00000, 8, 5'b00000, 0, 0});
        segs.push_back('{5'b00100, 4, 5'b00000, 0, 0});
        segs.push_back('{5'b00000, 2, 5'b00100, 1, 0});
        segs.push_back('{5'b00000, 6, 5'b00000, 0, 1});
        segs.push_back('{5'b10001, 5, 5'b00000, 0, 0});
        segs.push_back('{5'b10001, 1, 5'b10001, 2, 0});
        segs.push_back('{5'b00000, 6, 5'b00000, 0, 2});
        for (int s = 0; s < segs.size(); s++) begin
            bif.btn_raw = segs[s].raw;
            np = 0; nr = 0;
            for (int c = 0; c < segs[s].hold; c++) begin
                step();
                np += $countones(bif.btn_press);
                nr += $countones(bif.btn_release);
            end
            chk($sformatf("seg%0d_level", s), {bif.btn_level, 10'b0}, {segs[s].level, 10'b0});
            chk($sformatf("seg%0d_pulses", s), {10'(np), 5'(nr)}, {10'(segs[s].n_press), 5'(segs[s].n_rel)});
        end
        step(); step();
        chk("simul_press_bits", {bif.btn_level, 10'b0}, 15'b0);

        // Reset mid-debounce discards the pending press.
        bif.btn_raw = 5'b00001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pre_reset_no_pulse", {bif.btn_press, bif.btn_level, 5'b0}, 15'b0);
        end
        reset_n = 1'b0;
        step();
        chk("mid_reset_quiet", {bif.btn_level, bif.btn_press, bif.btn_release}, 15'b0);
        reset_n = 1'b1;
        expect_after(6, 5'b00001, 5'b00001, 5'b00000, "press_after_mid_reset");
        bif.btn_raw = 5'b00000;
        for (int i = 0; i < 8; i++) step();

        // Random pins with varying bounce density and occasional resets.
        for (int blk = 0; blk < 12; blk++) begin
            int unsigned odds;
            odds = (blk % 2 == 0) ? 32'd1 : 32'd7;
            for (int c = 0; c < 200; c++) begin
                logic [N-1:0] flip;
                for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, odds) == 0);
                bif.btn_raw = bif.btn_raw ^ flip;
                reset_n = ($urandom_range(0, 149) != 0);
                step();
            end
        end
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Synchronises, debounces and edge-detects the five Nexys push-buttons (C, U, D, L, R) before they reach the Pong game logic and its start/paddle controls. Each button gets a clean debounced level, a one-cycle press pulse and a one-cycle release pulse. The block sits between the top-level button pins and `pong_vga_bitchange`. It runs on the 100 MHz board clock.

## Interface
- `N_BTN`, 5: number of button channels. Bit map: 0=C, 1=U, 2=D, 3=L, 4=R.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required to accept a new level (10 ms at 100 MHz). Legal range ≥ 2.
- `clk`  in  1: board clock. All logic is on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `btn_raw`  in  N_BTN: asynchronous button pins, active-high.
- `btn_level`  out  N_BTN: debounced level.
- `btn_press`  out  N_BTN: one-cycle pulse on an accepted 0→1 transition.
- `btn_release`  out  N_BTN: one-cycle pulse on an accepted 1→0 transition.

## Operation
- **Synchroniser.** Each channel has a 2-FF synchroniser, `sync1` then `sync2`. Only `sync2` is used downstream.
- **Channel state machine.** Each channel runs an independent FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
  - IDLE (level 0): if `sync2`=1, load cnt=1 and go to PRESS_WAIT.
  - PRESS_WAIT: if `sync2`=0, clear cnt and return to IDLE (bounce rejected). Else if cnt=DEBOUNCE_CYCLES−1, go to HELD, set level=1 and pulse press. Else cnt++.
  - HELD (level 1): if `sync2`=0, load cnt=1 and go to RELEASE_WAIT.
  - RELEASE_WAIT: if `sync2`=1, clear cnt and return to HELD. Else if cnt=DEBOUNCE_CYCLES−1, go to IDLE, set level=0 and pulse release. Else cnt++.
- **Counter.** Width is clog2(DEBOUNCE_CYCLES). It is unsigned, never wraps, and saturation is unreachable by construction. Its value outside the WAIT states is don't-care but is held at 0.
- **Pulses.** Press and release pulses are registered and high for exactly one cycle. They can never be asserted on the same channel in the same cycle.
- **Channel independence.** Channels do not interact. Simultaneous presses on several buttons produce simultaneous pulses on the corresponding bits.
- **Reset.** Reset clears sync FFs, cnt, level, press and release to 0, and all FSMs go to IDLE.
  - A button held through reset produces a normal press once reset deasserts and debounce completes.
  - Reset asserted mid-debounce discards the pending transition. No pulse is emitted.

## Timing
- Reset values: `btn_level`=0, `btn_press`=0, `btn_release`=0.
- Latency: a pin level sampled at edge E appears on `sync2` after edge E+1. If it stays stable, `btn_level` and the pulse update after edge E+DEBOUNCE_CYCLES+1, i.e. D+2 cycles from first sample.
- Any opposite-level `sync2` sample during a WAIT state restarts the debounce. Glitches shorter than DEBOUNCE_CYCLES never reach `btn_level`.
- `btn_level` changes in the same cycle that the corresponding pulse is high.
- There is no combinational path from `btn_raw` to any output.

## Structure
- **Shared package `pong_pkg`:**
  - Channel FSM state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT).
  - Button index constants `BTN_C`=0, `BTN_U`=1, `BTN_D`=2, `BTN_L`=3, `BTN_R`=4.
  - `DEBOUNCE_CYCLES_DEFAULT`.
- **Sub-module `debounce_channel`:** one button containing its synchroniser, FSM, counter and pulse registers. It is instantiated N_BTN times with a generate loop.
- **Top-level wiring:** `btn_level` bits drive the paddle inputs and `btn_press[BTN_C]` drives start. The game logic no longer samples raw pins.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4 and N_BTN=5.
1. **Reset.** Hold `reset_n`=0 for 3 cycles with `btn_raw`=5'b11111. Outputs stay 0 throughout. After release, `btn_level` becomes 5'b11111 six cycles later, with `btn_press`=5'b11111 for one cycle.
2. **Clean press and release.** Set `btn_raw[1]` 0→1 and hold for 10 cycles. `btn_level[1]` rises 6 cycles after the first sample, with a single press pulse. Then release: `btn_level[1]` falls 6 cycles later, with a single release pulse.
3. **Bounce rejection.** Drive `btn_raw[3]` with a 1,0,1,0,1 pattern, one cycle each, then hold at 1. There are no pulses during the bounce. Exactly one press pulse occurs, 6 cycles after the final stable 1 is sampled.
4. **Short glitch.** A 3-cycle high pulse on `btn_raw[2]` leaves `btn_level[2]`=0 and produces no pulses. A 4-cycle pulse produces a press and later a release.
5. **Simultaneous buttons.** Press `btn_raw[0]` and `btn_raw[4]` on the same edge. Both press pulses assert in the same cycle, and the other bits stay 0.
6. **Reset mid-debounce.** Raise `btn_raw[0]`, then assert reset 3 cycles later for 1 cycle while still held. No pulse occurs before reset. One press occurs 6 cycles after reset deasserts.
